// File: rtl/cpu_pkg.sv
// Shared RV32I constants for the core: opcodes, forwarding-select encoding,
// hazard FSM states and the in-flight slot records.
package cpu_pkg;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111
    } opcode_e;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // The load flag only matters while an instruction sits in E, so M and W
    // carry the reduced record.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
    } slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
    } wslot_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return opc inside {OP, STORE, BRANCH, JALR, LOAD, OP_IMM};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OP, STORE, BRANCH};
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
        return !(opc inside {STORE, BRANCH}) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One source operand against the E/M/W slots: per-slot match vector plus the
// youngest-wins forwarding select.
module hazard_cmp
    import cpu_pkg::*;
(
    input  logic            used_i,
    input  logic [4:0]      src_i,
    input  logic [2:0]      wr_vld_i,
    input  logic [2:0][4:0] rd_i,
    output logic [2:0]      match_o,
    output logic [1:0]      sel_o
);

    // Index 0 is E (youngest), 2 is W (oldest).
    for (genvar k = 0; k < 3; k++) begin : g_slot
        assign match_o[k] = used_i & wr_vld_i[k] & (rd_i[k] == src_i);
    end

    always_comb begin
        sel_o = FWD_RF;
        if (match_o[0])      sel_o = FWD_E;
        else if (match_o[1]) sel_o = FWD_M;
        else if (match_o[2]) sel_o = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: E/M/W shadow scoreboard, stall/flush FSM and
// operand forwarding selects. Define HAZARD_FORWARDING_EN to enable forwarding.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_VALID,
    input  logic [6:0]  D_OPCODE,
    input  logic [4:0]  D_REG_D,
    input  logic [4:0]  D_REG_S1,
    input  logic [4:0]  D_REG_S2,
    input  logic        E_BRANCH_TAKEN,
    output logic        STALL,
    output logic        FLUSH,
    output logic [1:0]  FWD_S1_SEL,
    output logic [1:0]  FWD_S2_SEL,
    output logic [4:0]  W_REG_D,
    output logic        W_WEN,
    output logic [31:0] STALL_CNT
);

`ifdef HAZARD_FORWARDING_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    slot_t           e_q, e_d;
    wslot_t          m_q, w_q;
    logic [1:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic [1:0][4:0] src;
    logic [1:0]      used;
    logic [1:0][2:0] match;
    logic [1:0][1:0] sel;
    logic [2:0]      wr_vld;
    logic [2:0][4:0] rd_vec;
    logic [2:0]      haz_mask;
    logic            hazard, flush, stall;

    assign src    = {D_REG_S2, D_REG_S1};
    assign used   = {D_VALID & uses_rs2(D_OPCODE), D_VALID & uses_rs1(D_OPCODE)};
    assign wr_vld = {w_q.valid & w_q.wen, m_q.valid & m_q.wen, e_q.valid & e_q.wen};
    assign rd_vec = {w_q.rd, m_q.rd, e_q.rd};

    for (genvar g = 0; g < 2; g++) begin : g_src
        hazard_cmp u_cmp (
            .used_i   (used[g]),
            .src_i    (src[g]),
            .wr_vld_i (wr_vld),
            .rd_i     (rd_vec),
            .match_o  (match[g]),
            .sel_o    (sel[g])
        );
    end

    // With forwarding only a load still in E blocks; everything else is bypassed.
    assign haz_mask = FWD_ON ? {2'b00, e_q.is_load} : 3'b111;
    assign hazard   = |((match[0] | match[1]) & haz_mask);
    assign flush    = (state_q == ST_FLUSH) | E_BRANCH_TAKEN;
    assign stall    = hazard & ~flush;

    assign STALL      = stall;
    assign FLUSH      = flush;
    assign FWD_S1_SEL = (FWD_ON && !flush) ? sel[0] : FWD_RF;
    assign FWD_S2_SEL = (FWD_ON && !flush) ? sel[1] : FWD_RF;
    assign W_REG_D    = w_q.rd;
    assign W_WEN      = w_q.valid & w_q.wen;
    assign STALL_CNT  = stall_cnt_q;

    always_comb begin
        e_d = '0;
        if (D_VALID && !stall && !flush) begin
            e_d.valid   = 1'b1;
            e_d.rd      = D_REG_D;
            e_d.wen     = writes_rd(D_OPCODE, D_REG_D);
            e_d.is_load = (D_OPCODE == LOAD);
        end
    end

    // The branch cycle itself is the first flush cycle, so the counter only
    // covers the remaining FLUSH_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (E_BRANCH_TAKEN) begin
            cnt_d   = FLUSH_LOAD;
            state_d = (FLUSH_LOAD == 3'd0) ? ST_RUN : ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN:   if (hazard)  state_d = ST_STALL;
                ST_STALL: if (!hazard) state_d = ST_RUN;
                ST_FLUSH: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_d == 3'd0) state_d = ST_RUN;
                end
                default:  state_d = ST_RUN;
            endcase
        end
    end

    assign stall_cnt_d = stall_cnt_q + {31'd0, stall};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= '{valid: e_q.valid, rd: e_q.rd, wen: e_q.wen};
            w_q         <= m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// instruction streams against an instruction-level pipeline model.
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam logic [6:0] O_OP  = 7'b0110011, O_IMM = 7'b0010011, O_LD  = 7'b0000011,
                           O_ST  = 7'b0100011, O_BR  = 7'b1100011, O_JAL = 7'b1101111,
                           O_JR  = 7'b1100111, O_LUI = 7'b0110111, O_AUI = 7'b0010111,
                           O_SYS = 7'b1110011;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, D_VALID, E_BRANCH_TAKEN;
    logic [6:0]  D_OPCODE;
    logic [4:0]  D_REG_D, D_REG_S1, D_REG_S2;
    logic        STALL, FLUSH, W_WEN;
    logic [1:0]  FWD_S1_SEL, FWD_S2_SEL;
    logic [4:0]  W_REG_D;
    logic [31:0] STALL_CNT;

    hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .RST(RST), .D_VALID(D_VALID), .D_OPCODE(D_OPCODE),
        .D_REG_D(D_REG_D), .D_REG_S1(D_REG_S1), .D_REG_S2(D_REG_S2),
        .E_BRANCH_TAKEN(E_BRANCH_TAKEN), .STALL(STALL), .FLUSH(FLUSH),
        .FWD_S1_SEL(FWD_S1_SEL), .FWD_S2_SEL(FWD_S2_SEL),
        .W_REG_D(W_REG_D), .W_WEN(W_WEN), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // Instructions in flight, index 0 = youngest (E), 2 = oldest (W).
    typedef struct { bit v; int rd; bit wr; bit ld; } instr_t;
    instr_t      pipe [3];
    int          flush_left;
    bit [31:0]   stall_tot;
    int          n_cmp, n_err;
    logic [6:0]  ops [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit uses(input logic [6:0] op, input int which);
        if (which == 1) return op inside {O_OP, O_ST, O_BR, O_JR, O_LD, O_IMM};
        return op inside {O_OP, O_ST, O_BR};
    endfunction

    // Distance to the youngest in-flight producer of s: 1 = E, 2 = M, 3 = W, 0 = none.
    function automatic int producer(input bit u, input int s);
        if (!u) return 0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].v && pipe[k].wr && pipe[k].rd == s) return k + 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        flush_left = 0;
        stall_tot  = '0;
    endtask

    task automatic step(input bit v, input logic [6:0] op, input int rd, input int s1,
                        input int s2, input bit br);
        bit u1, u2, fl, haz, st;
        int p1, p2;
        @(negedge CLK);
        D_VALID = v; D_OPCODE = op; D_REG_D = 5'(rd);
        D_REG_S1 = 5'(s1); D_REG_S2 = 5'(s2); E_BRANCH_TAKEN = br;
        #1;
        u1  = v && uses(op, 1);
        u2  = v && uses(op, 2);
        p1  = producer(u1, s1);
        p2  = producer(u2, s2);
        fl  = br || (flush_left > 0);
        haz = FWD ? ((p1 == 1 || p2 == 1) && pipe[0].ld) : (p1 != 0 || p2 != 0);
        st  = haz && !fl;
        chk("stall", 32'(STALL), 32'(st));
        chk("flush", 32'(FLUSH), 32'(fl));
        chk("fwd1", 32'(FWD_S1_SEL), (FWD && !fl) ? 32'(p1) : 32'd0);
        chk("fwd2", 32'(FWD_S2_SEL), (FWD && !fl) ? 32'(p2) : 32'd0);
        chk("w_wen", 32'(W_WEN), 32'(pipe[2].v && pipe[2].wr));
        chk("w_rd", 32'(W_REG_D), pipe[2].v ? 32'(pipe[2].rd) : 32'd0);
        chk("stall_cnt", STALL_CNT, stall_tot);
        stall_tot = stall_tot + 32'(st);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (v && !st && !fl)
            pipe[0] = '{v: 1'b1, rd: rd, wr: !(op == O_ST || op == O_BR) && rd != 0, ld: op == O_LD};
        else
            pipe[0] = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        if (br) flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
    endtask

    // Caller positions time (normally a negedge); reset is asserted immediately.
    task automatic do_reset();
        RST = 1'b1; D_VALID = 1'b0; E_BRANCH_TAKEN = 1'b0;
        #1;
        chk("rst stall", 32'(STALL), 32'd0);
        chk("rst flush", 32'(FLUSH), 32'd0);
        chk("rst fwd", {30'd0, FWD_S1_SEL | FWD_S2_SEL}, 32'd0);
        chk("rst w_wen", 32'(W_WEN), 32'd0);
        chk("rst w_rd", 32'(W_REG_D), 32'd0);
        chk("rst cnt", STALL_CNT, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        RST = 1'b0; D_VALID = 1'b0; E_BRANCH_TAKEN = 1'b0;
        D_OPCODE = '0; D_REG_D = '0; D_REG_S1 = '0; D_REG_S2 = '0;
        ops = '{O_OP, O_IMM, O_LD, O_ST, O_BR, O_JAL, O_JR, O_LUI, O_AUI, O_SYS};
        model_clear();
        @(negedge CLK);
        do_reset();

        // x0 destination and store are not producers
        step(1, O_IMM, 0, 0, 0, 0);
        step(1, O_OP, 1, 0, 0, 0);
        chk("x0 stall", 32'(STALL), 32'd0);
        chk("x0 fwd", {30'd0, FWD_S1_SEL | FWD_S2_SEL}, 32'd0);
        step(1, O_ST, 3, 2, 3, 0);
        step(1, O_OP, 4, 3, 3, 0);
        chk("sw stall", 32'(STALL), 32'd0);
        chk("sw fwd", {30'd0, FWD_S1_SEL | FWD_S2_SEL}, 32'd0);

`ifdef HAZARD_FORWARDING_EN
        @(negedge CLK); do_reset();
        step(1, O_IMM, 5, 0, 0, 0);
        step(1, O_OP, 6, 5, 5, 0);
        chk("b2b stall", 32'(STALL), 32'd0);
        chk("b2b fwd1", 32'(FWD_S1_SEL), 32'd1);
        chk("b2b fwd2", 32'(FWD_S2_SEL), 32'd1);
        @(negedge CLK); do_reset();
        step(1, O_LD, 7, 1, 0, 0);
        step(1, O_OP, 8, 7, 0, 0);
        chk("lu stall", 32'(STALL), 32'd1);
        step(1, O_OP, 8, 7, 0, 0);
        chk("lu release", 32'(STALL), 32'd0);
        chk("lu fwd1", 32'(FWD_S1_SEL), 32'd2);
        chk("lu cnt", STALL_CNT, 32'd1);
`else
        @(negedge CLK); do_reset();
        step(1, O_IMM, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, O_OP, 6, 5, 5, 0);
            chk("dep stall", 32'(STALL), 32'(i < 3));
            if (i == 2) begin
                chk("dep w_wen", 32'(W_WEN), 32'd1);
                chk("dep w_rd", 32'(W_REG_D), 32'd5);
            end
        end
        chk("dep cnt", STALL_CNT, 32'd3);
`endif

        // taken branch over a pending load-use hazard
        @(negedge CLK); do_reset();
        step(1, O_LD, 7, 1, 0, 0);
        step(1, O_OP, 8, 7, 0, 1);
        chk("br flush0", 32'(FLUSH), 32'd1);
        chk("br stall0", 32'(STALL), 32'd0);
        step(1, O_OP, 8, 7, 0, 0);
        chk("br flush1", 32'(FLUSH), 32'd1);
        chk("br stall1", 32'(STALL), 32'd0);
        step(1, O_OP, 8, 7, 0, 0);
        chk("br flush end", 32'(FLUSH), 32'd0);
        step(0, O_OP, 0, 0, 0, 0);
        chk("br bubble0", 32'(W_WEN), 32'd0);
        step(0, O_OP, 0, 0, 0, 0);
        chk("br bubble1", 32'(W_WEN), 32'd0);

        // reset in the second flush cycle
        @(negedge CLK); do_reset();
        step(1, O_IMM, 9, 0, 0, 0);
        step(0, O_OP, 0, 0, 0, 1);
        @(negedge CLK);
        E_BRANCH_TAKEN = 1'b0; D_VALID = 1'b0;
        #1 chk("mid flush", 32'(FLUSH), 32'd1);
        do_reset();
        step(1, O_IMM, 10, 0, 0, 0);
        step(0, O_OP, 0, 0, 0, 0);
        step(0, O_OP, 0, 0, 0, 0);
        step(0, O_OP, 0, 0, 0, 0);
        chk("post rst w_wen", 32'(W_WEN), 32'd1);
        chk("post rst w_rd", 32'(W_REG_D), 32'd10);

        // randomized streams over a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                @(negedge CLK); do_reset();
            end
            step($urandom_range(0, 9) != 0, ops[$urandom_range(0, 9)],
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), $urandom_range(0, 11) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
